// File: rtl/ram_pkg.sv
// Shared defaults and state type for the RAM responder banks (RAM_X, RAM_Y).
// Word width must stay a multiple of 8 so byte enables cover it exactly.
package ram_pkg;

    localparam int unsigned RAM_ADDR_WIDTH = 9;
    localparam int unsigned RAM_DATA_WIDTH = 32;
    localparam int unsigned RAM_WE_WIDTH   = RAM_DATA_WIDTH / 8;

    typedef enum logic {
        CLEAR,
        READY
    } ram_state_t;

endpackage

// File: rtl/ram_clear_seq.sv
// Power-up clear sequencer: walks every word address once after reset, then raises ready.
// Instantiated by ram_responder only when RAM_CLEAR_EN is defined.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int unsigned DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  ready
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    ram_state_t state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= CLEAR;
            clr_addr <= '0;
            ready    <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_addr == LAST_ADDR) begin
                        state    <= READY;
                        ready    <= 1'b1;
                        clr_addr <= '0;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                READY: begin
                    state <= READY;
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

    // The reset edge itself must not clear; address 0 goes on the first edge with rst_n high.
    assign clr_we = rst_n && (state == CLEAR);

endmodule

// File: rtl/ram_responder.sv
// Single-port RAM responder: byte-enabled writes, read-first registered read data.
// Define RAM_CLEAR_EN to zero the whole array after each reset before ready rises.
module ram_responder
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = RAM_DATA_WIDTH,
    parameter int unsigned DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    EN,
    input  logic [DATA_WIDTH/8-1:0] WE,
    input  logic [ADDR_WIDTH-1:0]   A,
    input  logic [DATA_WIDTH-1:0]   Di,
    output logic [DATA_WIDTH-1:0]   Do,
    output logic                    ready
);

    localparam int unsigned WE_WIDTH = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  acc_en;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [WE_WIDTH-1:0]   wr_be;
    logic [DATA_WIDTH-1:0] wr_data;

    // Interface port is live only once ready was already high at this edge.
    assign acc_en = rst_n && ready && EN;

`ifdef RAM_CLEAR_EN
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    ram_clear_seq #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_clear_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (ready)
    );

    always_comb begin
        wr_en   = acc_en && (WE != '0);
        wr_addr = A;
        wr_be   = WE;
        wr_data = Di;
        if (clr_we) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr;
            wr_be   = '1;
            wr_data = '0;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready <= 1'b0;
        end else begin
            ready <= 1'b1;
        end
    end

    always_comb begin
        wr_en   = acc_en && (WE != '0);
        wr_addr = A;
        wr_be   = WE;
        wr_data = Di;
    end
`endif

    // Array has no reset; contents survive rst_n unless the clear sequencer runs.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < WE_WIDTH; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Nonblocking read of mem gives the pre-write word on a write cycle (read-first).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Do <= '0;
        end else if (acc_en) begin
            Do <= mem[A];
        end
    end

endmodule
